branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-stage branch predictor: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Each cycle, a combinational lookup on the fetch PC produces predict_taken and taken_pc. Both travel down the pipeline with the instruction and reach the WB-stage flush logic as predict_taken_wb / taken_pc_wb.
- The resolved branch outcome from WB is written back into the table to train it.

Parameters:
- INDEX_BITS, 3, log2 of the entry count (8 entries); index = pc[INDEX_BITS:1].
- CTR_INIT, 2'b01, counter value on reset (weakly not-taken).
- CTR_ALLOC, 2'b10, counter value on a new allocation (weakly taken).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears the table
- if_pc  input  16  fetch-stage PC (lc3b_word), word aligned
- predict_taken  output  1  prediction for the instruction at if_pc
- taken_pc  output  16  predicted next PC: BTB target if predicted taken, else if_pc+2
- wb_update  input  1  a branch/jump resolved in WB this cycle
- wb_pc  input  16  PC of the resolved instruction
- wb_taken  input  1  actual direction (pcmux_sel_out != 0)
- wb_target  input  16  actual target (pcmux_out)
- hit  output  1  if_pc matched a valid entry (debug/perf)

Behaviour:
- Entry fields: valid, tag = pc[15:INDEX_BITS+1], target[15:0], ctr[1:0].
- Lookup is purely combinational, with zero-cycle latency:
  - hit = valid[idx] & (tag[idx] == if_pc tag field).
  - predict_taken = hit & ctr[idx][1].
  - taken_pc = predict_taken ? target[idx] : if_pc + 16'd2, with the add wrapping mod 2^16 (0xFFFE+2 = 0x0000).
- Update is registered and takes effect in the cycle after wb_update=1. Actions by case:
  - Hit (valid and tag match on wb_pc):
    - ctr saturating increments if wb_taken, else decrements; 2'b11 stays at 11 and 2'b00 stays at 00.
    - If wb_taken, target is rewritten with wb_target.
  - Miss and wb_taken: allocate (overwrite) the entry with valid=1, tag, target=wb_target, ctr=CTR_ALLOC.
  - Miss and !wb_taken: no change.
- Simultaneous lookup and update to the same index: the lookup sees the pre-update contents (read-before-write). No bypass.
- wb_update=0: the table holds its state.
- Reset (synchronous, active-high) in any cycle, including one with wb_update=1:
  - All valid cleared and all ctr = CTR_INIT; reset wins over the update.
  - Targets and tags are don't-care.
  - Outputs during and after reset: predict_taken=0, hit=0, taken_pc=if_pc+2.
- No stall input: fetch holds if_pc while stalled, and the combinational output stays stable.
- The WB flush logic guarantees wb_update fires at most once per retired branch; this block does not check for duplicate updates.

Optional Feature:
- Macro: BRANCH_PREDICTOR_STATS_EN.
- With the macro defined, three extra 32-bit output ports, each a wrapping counter cleared by reset:
  - bp_lookups: +1 per cycle with wb_update=1.
  - bp_correct: +1 when wb_update=1 and the prediction recomputed from pre-update state at wb_pc matches wb_taken, and, for taken branches, the stored target equals wb_target.
  - bp_allocs: +1 per allocation.
- Without the macro: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- lc3b_types gains:
  - typedef lc3b_bp_ctr (logic [1:0]).
  - Constants BP_CTR_SNT=2'b00, BP_CTR_WNT=2'b01, BP_CTR_WT=2'b10, BP_CTR_ST=2'b11.
- Sub-module sat_counter2: a combinational next-state function (ctr, inc) -> next ctr, instanced once for the update path.
- Table arrays and update logic stay in branch_predictor.

Test Plan:
- Reset, then if_pc=0x3000 -> hit=0, predict_taken=0, taken_pc=0x3002.
- wb_update=1, wb_pc=0x3000, wb_taken=1, wb_target=0x3040; next cycle if_pc=0x3000 -> hit=1, predict_taken=1 (ctr=10), taken_pc=0x3040.
- Train 0x3000 taken twice more -> ctr=11. Then not-taken twice -> ctr=01, predict_taken=0, taken_pc=0x3002. Further not-taken updates leave ctr at 00.
- Alias: entry for 0x3000 present; taken update at wb_pc=0x3010 (same idx, different tag) -> 0x3000 misses, 0x3010 hits with ctr=10. A not-taken update on a missing PC leaves the table unchanged.
- Same-cycle update and lookup at 0x3000 -> the output reflects the old entry; the new one is visible the next cycle. Reset asserted together with wb_update -> the table is empty afterward.
- if_pc=0xFFFE on a miss -> taken_pc=0x0000. With BRANCH_PREDICTOR_STATS_EN, the earlier sequence yields the expected bp_lookups/bp_correct/bp_allocs counts.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// branch_predictor_pkg
//   Shared types and constants for the fetch-stage branch predictor.
//   - lc3b_word   : 16-bit machine word / PC
//   - lc3b_bp_ctr : 2-bit saturating direction counter
//   - BP_CTR_*    : named counter states (strong/weak, taken/not-taken)
// ---------------------------------------------------------------------------
package branch_predictor_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_bp_ctr;

    localparam lc3b_bp_ctr BP_CTR_SNT = 2'b00;  // strongly not-taken
    localparam lc3b_bp_ctr BP_CTR_WNT = 2'b01;  // weakly not-taken
    localparam lc3b_bp_ctr BP_CTR_WT  = 2'b10;  // weakly taken
    localparam lc3b_bp_ctr BP_CTR_ST  = 2'b11;  // strongly taken

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// ---------------------------------------------------------------------------
// sat_counter2
//   Combinational next-state function of a 2-bit saturating counter.
//   Ports:
//     i_ctr  in  2  current counter value
//     i_inc  in  1  1 = count towards taken, 0 = towards not-taken
//     o_ctr  out 2  next counter value (sticks at BP_CTR_ST / BP_CTR_SNT)
// ---------------------------------------------------------------------------
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_inc,
    output logic [1:0] o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_inc) begin
            if (i_ctr != BP_CTR_ST) begin
                o_ctr = i_ctr + 2'd1;
            end
        end else begin
            if (i_ctr != BP_CTR_SNT) begin
                o_ctr = i_ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped BTB with a 2-bit saturating direction counter per entry.
//   Lookup on if_pc is purely combinational; training from WB is registered
//   and becomes visible the cycle after wb_update. A same-cycle lookup of the
//   entry being trained sees the old contents (no bypass).
//
//   Ports:
//     clk            in   1   clock, rising edge
//     reset          in   1   synchronous active-high, clears valid/ctr
//     if_pc          in  16   fetch PC
//     predict_taken  out  1   predicted direction for if_pc
//     taken_pc       out 16   predicted next PC (target or if_pc+2)
//     wb_update      in   1   resolved branch/jump in WB this cycle
//     wb_pc          in  16   PC of the resolved instruction
//     wb_taken       in   1   actual direction
//     wb_target      in  16   actual target
//     hit            out  1   if_pc matched a valid entry
//
//   Optional (macro BRANCH_PREDICTOR_STATS_EN):
//     bp_lookups     out 32   resolved updates seen
//     bp_correct     out 32   updates whose prediction (direction + target
//                             when taken) was right
//     bp_allocs      out 32   new entries allocated
// ---------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         INDEX_BITS = 3,
    parameter logic [1:0] CTR_INIT   = BP_CTR_WNT,
    parameter logic [1:0] CTR_ALLOC  = BP_CTR_WT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] if_pc,
    output logic        predict_taken,
    output logic [15:0] taken_pc,
    input  logic        wb_update,
    input  logic [15:0] wb_pc,
    input  logic        wb_taken,
    input  logic [15:0] wb_target,
    output logic        hit
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0] bp_lookups,
    output logic [31:0] bp_correct,
    output logic [31:0] bp_allocs
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 16 - INDEX_BITS - 1;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    lc3b_word           r_target [ENTRIES];
    lc3b_bp_ctr         r_ctr    [ENTRIES];

    // Bit 0 of a PC is always zero for word-aligned instructions.
    logic w_unused;
    assign w_unused = if_pc[0] ^ wb_pc[0];

    // ---------------- lookup (fetch side) ----------------
    logic [INDEX_BITS-1:0] w_if_idx;
    logic [TAG_W-1:0]      w_if_tag;
    logic                  w_if_hit;

    assign w_if_idx = if_pc[INDEX_BITS:1];
    assign w_if_tag = if_pc[15:INDEX_BITS+1];

    // Gated by reset so the outputs are clean even before the first
    // reset edge has cleared the table.
    assign w_if_hit      = !reset && r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign hit           = w_if_hit;
    assign predict_taken = w_if_hit && r_ctr[w_if_idx][1];
    assign taken_pc      = predict_taken ? r_target[w_if_idx] : (if_pc + 16'd2);

    // ---------------- training (WB side) ----------------
    logic [INDEX_BITS-1:0] w_wb_idx;
    logic [TAG_W-1:0]      w_wb_tag;
    logic                  w_wb_hit;
    logic                  w_wb_alloc;
    lc3b_bp_ctr            w_ctr_next;

    assign w_wb_idx   = wb_pc[INDEX_BITS:1];
    assign w_wb_tag   = wb_pc[15:INDEX_BITS+1];
    assign w_wb_hit   = r_valid[w_wb_idx] && (r_tag[w_wb_idx] == w_wb_tag);
    assign w_wb_alloc = wb_update && !w_wb_hit && wb_taken;

    sat_counter2 u_sat_counter2 (
        .i_ctr (r_ctr[w_wb_idx]),
        .i_inc (wb_taken),
        .o_ctr (w_ctr_next)
    );

    // Tags and targets are left untouched by reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= CTR_INIT;
            end
        end else if (wb_update) begin
            if (w_wb_hit) begin
                r_ctr[w_wb_idx] <= w_ctr_next;
                if (wb_taken) begin
                    r_target[w_wb_idx] <= wb_target;
                end
            end else if (wb_taken) begin
                r_valid[w_wb_idx]  <= 1'b1;
                r_tag[w_wb_idx]    <= w_wb_tag;
                r_target[w_wb_idx] <= wb_target;
                r_ctr[w_wb_idx]    <= CTR_ALLOC;
            end
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    // Prediction the table would have made for wb_pc, from pre-update state.
    logic w_wb_pred;
    logic w_wb_correct;

    assign w_wb_pred    = w_wb_hit && r_ctr[w_wb_idx][1];
    assign w_wb_correct = (w_wb_pred == wb_taken) &&
                          (!wb_taken || (r_target[w_wb_idx] == wb_target));

    always_ff @(posedge clk) begin
        if (reset) begin
            bp_lookups <= '0;
            bp_correct <= '0;
            bp_allocs  <= '0;
        end else if (wb_update) begin
            bp_lookups <= bp_lookups + 32'd1;
            if (w_wb_correct) begin
                bp_correct <= bp_correct + 32'd1;
            end
            if (w_wb_alloc) begin
                bp_allocs <= bp_allocs + 32'd1;
            end
        end
    end
`else
    logic w_unused_alloc;
    assign w_unused_alloc = w_wb_alloc;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [15:0] if_pc;
    logic        predict_taken;
    logic [15:0] taken_pc;
    logic        wb_update;
    logic [15:0] wb_pc;
    logic        wb_taken;
    logic [15:0] wb_target;
    logic        hit;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] bp_lookups;
    logic [31:0] bp_correct;
    logic [31:0] bp_allocs;
`endif

    int n_vec;
    int n_err;
    int exp_lookups;
    int exp_correct;
    int exp_allocs;

    branch_predictor dut (
        .clk           (clk),
        .reset         (reset),
        .if_pc         (if_pc),
        .predict_taken (predict_taken),
        .taken_pc      (taken_pc),
        .wb_update     (wb_update),
        .wb_pc         (wb_pc),
        .wb_taken      (wb_taken),
        .wb_target     (wb_target),
        .hit           (hit)
`ifdef BRANCH_PREDICTOR_STATS_EN
        ,
        .bp_lookups    (bp_lookups),
        .bp_correct    (bp_correct),
        .bp_allocs     (bp_allocs)
`endif
    );

    // clock: period 10, rising edges at 5, 15, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive if_pc and check the combinational lookup (no clock edge).
    task automatic look(input string tag, input logic [15:0] pc, input logic e_hit,
                        input logic e_pt, input logic [15:0] e_tpc);
        if_pc = pc;
        #1;
        check({tag, ".hit"},      {31'd0, hit},           {31'd0, e_hit});
        check({tag, ".pred"},     {31'd0, predict_taken}, {31'd0, e_pt});
        check({tag, ".taken_pc"}, {16'd0, taken_pc},      {16'd0, e_tpc});
    endtask

    // One WB update lasting a single clock; c/a are the hand-derived
    // "prediction was correct" and "allocates" flags for the stats model.
    task automatic upd(input logic [15:0] pc, input logic t, input logic [15:0] tgt,
                       input logic c, input logic a);
        wb_update = 1'b1;
        wb_pc     = pc;
        wb_taken  = t;
        wb_target = tgt;
        exp_lookups++;
        if (c) exp_correct++;
        if (a) exp_allocs++;
        @(posedge clk);
        #1;
        wb_update = 1'b0;
        wb_taken  = 1'b0;
    endtask

    task automatic check_stats(input string tag);
`ifdef BRANCH_PREDICTOR_STATS_EN
        check({tag, ".lookups"}, bp_lookups, exp_lookups);
        check({tag, ".correct"}, bp_correct, exp_correct);
        check({tag, ".allocs"},  bp_allocs,  exp_allocs);
`else
        if (tag.len() == 0) n_vec = n_vec + 0;
`endif
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        exp_lookups = 0; exp_correct = 0; exp_allocs = 0;
        reset = 1'b1; wb_update = 1'b0; wb_pc = 16'h0; wb_taken = 1'b0;
        wb_target = 16'h0; if_pc = 16'h3000;

        // outputs during reset
        look("in_reset", 16'h3000, 1'b0, 1'b0, 16'h3002);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        look("after_reset", 16'h3000, 1'b0, 1'b0, 16'h3002);
        check_stats("stats_reset");

        // allocate 0x3000; the same-cycle lookup still sees the empty entry
        wb_update = 1'b1; wb_pc = 16'h3000; wb_taken = 1'b1; wb_target = 16'h3040;
        look("alloc_same_cycle", 16'h3000, 1'b0, 1'b0, 16'h3002);
        wb_update = 1'b0;
        upd(16'h3000, 1'b1, 16'h3040, 1'b0, 1'b1);                 // ctr 10
        look("alloc_next", 16'h3000, 1'b1, 1'b1, 16'h3040);

        upd(16'h3000, 1'b1, 16'h3040, 1'b1, 1'b0);                 // ctr 11
        upd(16'h3000, 1'b1, 16'h3040, 1'b1, 1'b0);                 // stays 11
        upd(16'h3000, 1'b0, 16'h0000, 1'b0, 1'b0);                 // 10
        look("st_minus1", 16'h3000, 1'b1, 1'b1, 16'h3040);
        upd(16'h3000, 1'b0, 16'h0000, 1'b0, 1'b0);                 // 01
        look("wnt", 16'h3000, 1'b1, 1'b0, 16'h3002);
        upd(16'h3000, 1'b0, 16'h0000, 1'b1, 1'b0);                 // 00
        upd(16'h3000, 1'b0, 16'h0000, 1'b1, 1'b0);                 // stays 00
        upd(16'h3000, 1'b1, 16'h3040, 1'b0, 1'b0);                 // 01
        look("snt_floor", 16'h3000, 1'b1, 1'b0, 16'h3002);
        upd(16'h3000, 1'b1, 16'h3040, 1'b0, 1'b0);                 // 10
        look("retrain", 16'h3000, 1'b1, 1'b1, 16'h3040);
        upd(16'h3000, 1'b1, 16'h3080, 1'b0, 1'b0);                 // 11, new target
        look("target_rewrite", 16'h3000, 1'b1, 1'b1, 16'h3080);

        // alias: 0x3010 shares index 0 with 0x3000
        upd(16'h3010, 1'b1, 16'h3100, 1'b0, 1'b1);
        look("alias_old", 16'h3000, 1'b0, 1'b0, 16'h3002);
        look("alias_new", 16'h3010, 1'b1, 1'b1, 16'h3100);
        // not-taken on a missing PC changes nothing
        upd(16'h3000, 1'b0, 16'h0000, 1'b1, 1'b0);
        look("nt_miss_a", 16'h3000, 1'b0, 1'b0, 16'h3002);
        look("nt_miss_b", 16'h3010, 1'b1, 1'b1, 16'h3100);

        // read-before-write on a hit entry (10 -> 01)
        wb_update = 1'b1; wb_pc = 16'h3010; wb_taken = 1'b0; wb_target = 16'h0;
        look("rbw_old", 16'h3010, 1'b1, 1'b1, 16'h3100);
        wb_update = 1'b0;
        upd(16'h3010, 1'b0, 16'h0000, 1'b0, 1'b0);
        look("rbw_new", 16'h3010, 1'b1, 1'b0, 16'h3012);

        // another index, then hold with wb_update low
        upd(16'h3004, 1'b1, 16'h2000, 1'b0, 1'b1);
        look("idx2", 16'h3004, 1'b1, 1'b1, 16'h2000);
        wb_pc = 16'h3006; wb_taken = 1'b1; wb_target = 16'h4444;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wb_taken = 1'b0;
        look("hold", 16'h3006, 1'b0, 1'b0, 16'h3008);
        check_stats("stats_mid");

        // reset together with an update: reset wins
        reset = 1'b1;
        upd(16'h3006, 1'b1, 16'h5555, 1'b0, 1'b0);
        reset = 1'b0;
        exp_lookups = 0; exp_correct = 0; exp_allocs = 0;
        check_stats("stats_cleared");
        look("rst_upd_a", 16'h3006, 1'b0, 1'b0, 16'h3008);
        look("rst_upd_b", 16'h3004, 1'b0, 1'b0, 16'h3006);
        look("rst_upd_c", 16'h3010, 1'b0, 1'b0, 16'h3012);

        // fall-through wrap at the top of memory
        look("wrap_miss", 16'hFFFE, 1'b0, 1'b0, 16'h0000);
        upd(16'hFFFE, 1'b1, 16'h1234, 1'b0, 1'b1);
        look("wrap_hit", 16'hFFFE, 1'b1, 1'b1, 16'h1234);
        upd(16'hFFFE, 1'b1, 16'h1234, 1'b1, 1'b0);
        look("wrap_st", 16'hFFFE, 1'b1, 1'b1, 16'h1234);
        check_stats("stats_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
